stream_demux_1to2: RTL and testbench
====================================

STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter: WIDTH, default 2, data word width in bits.
REQ-002 Port: Clk  input  1  rising-edge clock for all state.
REQ-003 Port: Rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: in_data  input  WIDTH  upstream word.
REQ-005 Port: in_sel  input  1  destination select; 0 = output A, 1 = output B.
REQ-006 Port: in_valid  input  1  upstream word and select are valid.
REQ-007 Port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 Port: outA_data / outB_data  output  WIDTH  registered word held for A / B.
REQ-009 Port: outA_valid / outB_valid  output  1  A / B holds an undelivered word.
REQ-010 Port: outA_ready / outB_ready  input  1  downstream A / B consumes the held word this cycle.

Function
REQ-011 Each output SHALL have one holding register (data plus valid flag); the block SHALL have no other datapath storage.
REQ-012 An output transfer SHALL occur on a rising edge with outX_valid=1 and outX_ready=1; outX_valid then clears unless it is reloaded on the same edge.
REQ-013 in_ready SHALL be combinational: 1 when the register selected by in_sel is empty or is transferring this cycle; otherwise 0.
REQ-014 in_ready SHALL NOT depend on the unselected register: head-of-line blocking is intended.
REQ-015 On an acceptance edge (in_valid=1 and in_ready=1), the register selected by in_sel SHALL load in_data and set its valid flag; latency is 1 cycle.
REQ-016 A simultaneous output transfer and reload of the same register SHALL leave valid=1 with the new data, giving one word per cycle per output.
REQ-017 The unselected register SHALL be unaffected by an acceptance and SHALL drain independently.
REQ-018 outX_data SHALL remain stable while outX_valid=1 and the word is not transferred.
REQ-019 Upstream SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the block does not check this.
REQ-020 With in_valid=0, no register SHALL load, and in_ready still follows REQ-013.
REQ-021 outX_ready SHALL be ignored while outX_valid=0.

Reset
REQ-022 While Rst_n=0: outA_valid=outB_valid=0, outA_data=outB_data=0, and in_ready is forced to 0.
REQ-023 Reset asserted mid-operation SHALL discard the held words without delivering them.
REQ-024 The first acceptance SHALL be possible on the first rising edge after Rst_n deasserts.

Configuration
REQ-025 Macro DEMUX_XFER_COUNT_EN SHALL, when defined, add output ports cntA and cntB (8 bits each).
REQ-026 Each counter SHALL count completed output transfers on its port, saturate at 255, and reset to 0.
REQ-027 When DEMUX_XFER_COUNT_EN is undefined, the counter ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Basic routing: reset, then in_data=2'b10, in_sel=0, in_valid=1, outA_ready=0 for 1 cycle -> next cycle outA_valid=1, outA_data=2'b10, outB_valid=0; in_ready=0 while in_sel=0.
REQ-029 Head-of-line blocking: A full, outA_ready=0, present in_sel=0, in_valid=1 -> in_ready=0 and B stays empty. Then present in_sel=1 -> in_ready=1, and B loads on the next edge.
REQ-030 Full throughput: outA_ready=1 held, in_valid=1, in_sel=0, words 0,1,2,3 on consecutive cycles -> outA_data shows 0,1,2,3 on consecutive cycles, outA_valid stays 1 throughout, in_ready stays 1.
REQ-031 Mid-operation reset: A and B both full, pulse Rst_n=0 between clock edges -> both valids clear immediately (asynchronously). After release, in_ready=1 and no stale word appears on either output.
REQ-032 With DEMUX_XFER_COUNT_EN defined: 300 back-to-back transfers on B, 3 on A -> cntB=255 (saturated), cntA=3. Rebuild without the macro and rerun REQ-028..031 -> identical results.

Source files
------------

// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1:2 stream demux: one upstream port, two downstream ports.
// slave is the demux side; master is the environment that feeds and drains it.
interface stream_demux_1to2_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] outA_data;
    logic             outA_valid;
    logic             outA_ready;

    logic [WIDTH-1:0] outB_data;
    logic             outB_valid;
    logic             outB_ready;

    modport slave (
        input  in_data, in_sel, in_valid, outA_ready, outB_ready,
        output in_ready, outA_data, outA_valid, outB_data, outB_valid
    );

    modport master (
        output in_data, in_sel, in_valid, outA_ready, outB_ready,
        input  in_ready, outA_data, outA_valid, outB_data, outB_valid
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// 1:2 stream demux, one holding register per output; 1-cycle latency, full rate per output.
// Backpressure: in_ready follows only the selected output (head-of-line blocking); DEMUX_XFER_COUNT_EN adds cntA/cntB.
module stream_demux_1to2 #(
    parameter int WIDTH = 2
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    stream_demux_1to2_if.slave     bus
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [7:0]             cntA,
    output logic [7:0]             cntB
`endif
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
    } hold_t;

    hold_t a_q;
    hold_t b_q;

    logic a_xfer;
    logic b_xfer;
    logic a_free;
    logic b_free;
    logic acc;
    logic a_load;
    logic b_load;

    assign a_xfer = a_q.vld & bus.outA_ready;
    assign b_xfer = b_q.vld & bus.outB_ready;

    // A register can take a new word if it is empty or its word leaves on this edge.
    assign a_free = ~a_q.vld | bus.outA_ready;
    assign b_free = ~b_q.vld | bus.outB_ready;

    assign bus.in_ready = Rst_n & (bus.in_sel ? b_free : a_free);

    assign acc    = bus.in_valid & bus.in_ready;
    assign a_load = acc & ~bus.in_sel;
    assign b_load = acc &  bus.in_sel;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_q <= '0;
        end else if (a_load) begin
            a_q.vld <= 1'b1;
            a_q.dat <= bus.in_data;
        end else if (a_xfer) begin
            a_q.vld <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            b_q <= '0;
        end else if (b_load) begin
            b_q.vld <= 1'b1;
            b_q.dat <= bus.in_data;
        end else if (b_xfer) begin
            b_q.vld <= 1'b0;
        end
    end

    assign bus.outA_valid = a_q.vld;
    assign bus.outA_data  = a_q.dat;
    assign bus.outB_valid = b_q.vld;
    assign bus.outB_data  = b_q.dat;

`ifdef DEMUX_XFER_COUNT_EN
    // Saturating counts of completed downstream transfers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cntA <= 8'd0;
            cntB <= 8'd0;
        end else begin
            if (a_xfer && cntA != 8'hff) cntA <= cntA + 8'd1;
            if (b_xfer && cntB != 8'hff) cntB <= cntB + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed scenarios then random traffic against a queue model.
module tb_stream_demux_1to2;
    localparam int W = 2;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    stream_demux_1to2_if #(.WIDTH(W)) bus();

`ifdef DEMUX_XFER_COUNT_EN
    logic [7:0] cntA;
    logic [7:0] cntB;
`endif

    stream_demux_1to2 #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .cntA  (cntA),
        .cntB  (cntB)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Each output holds at most one undelivered word; a queue models it directly.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int  ca = 0;
    int  cb = 0;
    bit  last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("outA_valid", 32'(bus.outA_valid), 32'(qa.size() != 0));
        chk("outB_valid", 32'(bus.outB_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) chk("outA_data", 32'(bus.outA_data), 32'(qa[0]));
        if (qb.size() != 0) chk("outB_data", 32'(bus.outB_data), 32'(qb[0]));
`ifdef DEMUX_XFER_COUNT_EN
        chk("cntA", 32'(cntA), 32'(ca));
        chk("cntB", 32'(cntB), 32'(cb));
`endif
    endtask

    // One clock: drive after the falling edge, check in_ready before the rising edge,
    // advance the model on the rising edge, check the outputs just after it.
    task automatic cyc(input logic [W-1:0] d, input logic s, input logic v,
                       input logic ra, input logic rb);
        logic exp_rdy;
        bus.in_data    = d;
        bus.in_sel     = s;
        bus.in_valid   = v;
        bus.outA_ready = ra;
        bus.outB_ready = rb;
        #1;
        exp_rdy = s ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge Clk);
        if (qa.size() != 0 && ra) begin
            void'(qa.pop_front());
            if (ca < 255) ca++;
        end
        if (qb.size() != 0 && rb) begin
            void'(qb.pop_front());
            if (cb < 255) cb++;
        end
        last_acc = v && exp_rdy;
        if (last_acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        #1;
        check_outs();
        @(negedge Clk);
    endtask

    task automatic reset_pulse();
        #2;
        Rst_n = 1'b0;
        qa.delete();
        qb.delete();
        ca = 0;
        cb = 0;
        #1;
        chk("rst_outA_valid", 32'(bus.outA_valid), 32'd0);
        chk("rst_outB_valid", 32'(bus.outB_valid), 32'd0);
        chk("rst_outA_data",  32'(bus.outA_data),  32'd0);
        chk("rst_outB_data",  32'(bus.outB_data),  32'd0);
        chk("rst_in_ready",   32'(bus.in_ready),   32'd0);
        #1;
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         s;
        logic         v;

        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b1;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        #2;
        chk("rst_outA_valid", 32'(bus.outA_valid), 32'd0);
        chk("rst_outB_valid", 32'(bus.outB_valid), 32'd0);
        chk("rst_outA_data",  32'(bus.outA_data),  32'd0);
        chk("rst_outB_data",  32'(bus.outB_data),  32'd0);
        chk("rst_in_ready",   32'(bus.in_ready),   32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Basic routing; acceptance on the first edge after reset release.
        cyc(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("route_a_data", 32'(bus.outA_data), 32'h2);
        chk("route_b_empty", 32'(bus.outB_valid), 32'd0);

        // Head-of-line: A stuck, word for A blocks; switching to B gets through.
        cyc(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hol_a_held", 32'(bus.outA_data), 32'h2);
        cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("hol_b_loaded", 32'(bus.outB_data), 32'h1);
        cyc(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Full throughput on A.
        for (int i = 0; i < 4; i++) begin
            cyc(W'(i), 1'b0, 1'b1, 1'b1, 1'b0);
            chk("thru_a_data", 32'(bus.outA_data), 32'(i));
        end
        cyc(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mid-operation reset with both registers full.
        cyc(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        reset_pulse();
        cyc(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

        // Transfer counting: 300 on B, 3 on A, from a clean reset.
        reset_pulse();
        for (int i = 0; i < 300; i++) cyc(W'(i), 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)   cyc(W'(i), 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DEMUX_XFER_COUNT_EN
        chk("cntB_sat", 32'(cntB), 32'd255);
        chk("cntA_3",   32'(cntA), 32'd3);
`endif

        // Random traffic; upstream holds its word while stalled.
        d = '0;
        s = 1'b0;
        v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(v && !last_acc)) begin
                d = W'($urandom);
                s = 1'($urandom);
                v = ($urandom_range(0, 3) != 0);
            end
            cyc(d, s, v, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
